// File: rtl/sensor_agua_ultrassom_pkg.sv
// Shared constants for the coffee-machine water-level sensor.
//   - estado_t : FSM state encodings (also exported on db_estado)
//   - default timing constants for a 50 MHz system clock
//   - default water-sufficient threshold in centimetres
package sensor_agua_ultrassom_pkg;

  typedef enum logic [2:0] {
    OCIOSO       = 3'b000,
    GERA_TRIGGER = 3'b001,
    ESPERA_ECHO  = 3'b010,
    MEDE_ECHO    = 3'b011,
    CONCLUI      = 3'b100,
    FALHA_ST     = 3'b101
  } estado_t;

  localparam int unsigned CLOCK_HZ             = 50_000_000;
  localparam int unsigned TRIGGER_CYCLES_DEF   = 500;        // 10 us
  localparam int unsigned CYCLES_PER_CM_DEF    = 2941;       // 58.82 us per cm
  localparam int unsigned LIMIAR_CM_DEF        = 10;
  localparam int unsigned ECHO_TIMEOUT_DEF     = 1_500_000;  // 30 ms per echo phase
  localparam int unsigned DIST_WIDTH_DEF       = 9;

endpackage

// File: rtl/sensor_agua_ultrassom_contador_cm.sv
// Centimetre counter for the echo-width measurement.
// A prescaler divides the enabled clocks by CYCLES_PER_CM; every prescaler
// wrap advances the centimetre count, which saturates at all-ones.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : synchronous clear of prescaler and count (wins over enable)
//   enable       : count this clock
//   cm           : centimetres accumulated so far
module sensor_agua_ultrassom_contador_cm
  import sensor_agua_ultrassom_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM = CYCLES_PER_CM_DEF,
  parameter int unsigned DIST_WIDTH    = DIST_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  output logic [DIST_WIDTH-1:0] cm
);

  // A one-clock-per-cm prescaler still needs a 1-bit register that stays 0.
  localparam int unsigned PRE_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam logic [PRE_W-1:0]      PRE_FIM = PRE_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_WIDTH-1:0] CM_MAX  = '1;

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
      cm  <= '0;
    end else if (clear) begin
      pre <= '0;
      cm  <= '0;
    end else if (enable) begin
      if (pre == PRE_FIM) begin
        pre <= '0;
        if (cm != CM_MAX) cm <= cm + DIST_WIDTH'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_agua_ultrassom.sv
// HC-SR04 water-level responder for the coffee-machine control unit.
// On medir it fires a trigger pulse, times the echo pulse, converts the width
// to centimetres and reports whether the water surface is close enough.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   zera         : synchronous abort/clear (priority over medir)
//   medir        : single-cycle start request, honoured only when idle
//   echo         : raw echo pin (asynchronous)
//   trigger      : trigger pin to the sensor
//   pronto       : result valid level
//   suficiente   : distancia <= LIMIAR_CM, valid with pronto
//   falha        : timeout level
//   distancia    : measured distance in cm
//   db_estado    : current FSM state encoding
module sensor_agua_ultrassom
  import sensor_agua_ultrassom_pkg::*;
#(
  parameter int unsigned TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
  parameter int unsigned CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
  parameter int unsigned LIMIAR_CM      = LIMIAR_CM_DEF,
  parameter int unsigned ECHO_TIMEOUT   = ECHO_TIMEOUT_DEF,
  parameter int unsigned DIST_WIDTH     = DIST_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  zera,
  input  logic                  medir,
  input  logic                  echo,
  output logic                  trigger,
  output logic                  pronto,
  output logic                  suficiente,
  output logic                  falha,
  output logic [DIST_WIDTH-1:0] distancia,
  output logic [2:0]            db_estado
);

  // One counter serves both the trigger width and the echo timeouts; it
  // restarts on every state change.
  localparam int unsigned CNT_MAX = (TRIGGER_CYCLES > ECHO_TIMEOUT) ? TRIGGER_CYCLES : ECHO_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]      TRIG_FIM    = CNT_W'(TRIGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_FIM = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [DIST_WIDTH-1:0] LIMIAR      = DIST_WIDTH'(LIMIAR_CM);

  function automatic logic dentro_limiar(input logic [DIST_WIDTH-1:0] dist_cm);
    return (dist_cm <= LIMIAR);
  endfunction

  estado_t                 estado, estado_prox;
  logic [CNT_W-1:0]        contador;
  logic                    echo_p0, echo_p1;
  logic                    echo_s;
  logic                    cm_clear, cm_enable;
  logic [DIST_WIDTH-1:0]   cm;

  // Stage p0/p1: two-flop synchronizer for the echo pin
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_p0 <= 1'b0;
      echo_p1 <= 1'b0;
    end else begin
      echo_p0 <= echo;
      echo_p1 <= echo_p0;
    end
  end
  assign echo_s = echo_p1;

  // Every synchronized high cycle is counted, including the one that moves
  // espera_echo into mede_echo, so N high cycles give floor(N/CYCLES_PER_CM).
  assign cm_clear  = zera || (estado == OCIOSO) || (estado == GERA_TRIGGER);
  assign cm_enable = echo_s && ((estado == ESPERA_ECHO) || (estado == MEDE_ECHO));

  sensor_agua_ultrassom_contador_cm #(
    .CYCLES_PER_CM (CYCLES_PER_CM),
    .DIST_WIDTH    (DIST_WIDTH)
  ) u_contador_cm (
    .clock  (clock),
    .reset  (reset),
    .clear  (cm_clear),
    .enable (cm_enable),
    .cm     (cm)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    if (zera) begin
      estado_prox = OCIOSO;
    end else begin
      case (estado)
        OCIOSO:       if (medir) estado_prox = GERA_TRIGGER;
        GERA_TRIGGER: if (contador == TRIG_FIM) estado_prox = ESPERA_ECHO;
        ESPERA_ECHO: begin
          if (echo_s)                        estado_prox = MEDE_ECHO;
          else if (contador == TIMEOUT_FIM)  estado_prox = FALHA_ST;
        end
        MEDE_ECHO: begin
          if (!echo_s)                       estado_prox = CONCLUI;
          else if (contador == TIMEOUT_FIM)  estado_prox = FALHA_ST;
        end
        CONCLUI:      estado_prox = OCIOSO;
        FALHA_ST:     estado_prox = OCIOSO;
        default:      estado_prox = OCIOSO;
      endcase
    end
  end

  // Trigger is decoded from the state register so an asynchronous reset
  // drops it immediately.
  always_comb begin
    trigger   = (estado == GERA_TRIGGER);
    db_estado = estado;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador <= '0;
    end else if (zera || (estado_prox != estado) || (estado == OCIOSO)) begin
      contador <= '0;
    end else begin
      contador <= contador + CNT_W'(1);
    end
  end

  // Result registers hold until the next accepted medir, zera or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pronto     <= 1'b0;
      suficiente <= 1'b0;
      falha      <= 1'b0;
      distancia  <= '0;
    end else if (zera) begin
      pronto     <= 1'b0;
      suficiente <= 1'b0;
      falha      <= 1'b0;
      distancia  <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (medir) begin
            pronto     <= 1'b0;
            suficiente <= 1'b0;
            falha      <= 1'b0;
            distancia  <= '0;
          end
        end
        CONCLUI: begin
          distancia  <= cm;
          suficiente <= dentro_limiar(cm);
          pronto     <= 1'b1;
          falha      <= 1'b0;
        end
        FALHA_ST: begin
          falha      <= 1'b1;
          pronto     <= 1'b0;
          suficiente <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_agua_ultrassom.sv
module tb_sensor_agua_ultrassom;

  logic       clock = 1'b0;
  logic       reset;
  logic       zera, medir, echo;
  logic       trigger, pronto, suficiente, falha;
  logic [8:0] distancia;
  logic [2:0] db_estado;

  // Second instance: one clock per cm, long timeout, for saturation
  logic       zera_s, medir_s, echo_sp;
  logic       trigger_s, pronto_s, suficiente_s, falha_s;
  logic [8:0] distancia_s;
  logic [2:0] db_estado_s;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sensor_agua_ultrassom #(
    .TRIGGER_CYCLES (5),
    .CYCLES_PER_CM  (4),
    .LIMIAR_CM      (10),
    .ECHO_TIMEOUT   (200),
    .DIST_WIDTH     (9)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .zera       (zera),
    .medir      (medir),
    .echo       (echo),
    .trigger    (trigger),
    .pronto     (pronto),
    .suficiente (suficiente),
    .falha      (falha),
    .distancia  (distancia),
    .db_estado  (db_estado)
  );

  sensor_agua_ultrassom #(
    .TRIGGER_CYCLES (5),
    .CYCLES_PER_CM  (1),
    .LIMIAR_CM      (10),
    .ECHO_TIMEOUT   (1000),
    .DIST_WIDTH     (9)
  ) u_dut_sat (
    .clock      (clock),
    .reset      (reset),
    .zera       (zera_s),
    .medir      (medir_s),
    .echo       (echo_sp),
    .trigger    (trigger_s),
    .pronto     (pronto_s),
    .suficiente (suficiente_s),
    .falha      (falha_s),
    .distancia  (distancia_s),
    .db_estado  (db_estado_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse medir and return how many sampled cycles trigger stayed high.
  // Returns at the first sample with the FSM in espera_echo.
  task automatic inicia(output int trig_len);
    int n;
    medir = 1'b1;
    tick();
    medir = 1'b0;
    n = 0;
    while (trigger && n < 50) begin
      n++;
      tick();
    end
    trig_len = n;
  endtask

  // Full measurement: echo rises 10 clocks after trigger falls and stays high
  // for 'largura' clocks; lat = clocks from echo pin fall to pronto/falha.
  task automatic mede(input int largura, output int trig_len, output int lat);
    int n;
    inicia(trig_len);
    repeat (10) tick();
    echo = 1'b1;
    repeat (largura) tick();
    echo = 1'b0;
    n = 0;
    while (!pronto && !falha && n < 20) begin
      tick();
      n++;
    end
    lat = n;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tl, lt, n;
    reset = 1'b1; zera = 1'b0; medir = 1'b0; echo = 1'b0;
    zera_s = 1'b0; medir_s = 1'b0; echo_sp = 1'b0;
    repeat (3) tick();
    chk("rst_trigger", trigger, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_suficiente", suficiente, 0);
    chk("rst_falha", falha, 0);
    chk("rst_distancia", distancia, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;
    tick();

    // 40 high cycles / 4 per cm = 10 cm, equal to threshold -> sufficient
    mede(40, tl, lt);
    chk("nom_trig_len", tl, 5);
    chk("nom_latency", lt, 4);
    chk("nom_distancia", distancia, 10);
    chk("nom_suficiente", suficiente, 1);
    chk("nom_pronto", pronto, 1);
    chk("nom_falha", falha, 0);
    chk("nom_estado", db_estado, 0);

    // zera in idle clears the held result
    zera = 1'b1;
    tick();
    zera = 1'b0;
    chk("zera_pronto", pronto, 0);
    chk("zera_distancia", distancia, 0);
    chk("zera_suficiente", suficiente, 0);

    // 44 cycles -> 11 cm, above threshold
    mede(44, tl, lt);
    chk("ins_latency", lt, 4);
    chk("ins_distancia", distancia, 11);
    chk("ins_suficiente", suficiente, 0);
    chk("ins_pronto", pronto, 1);

    // 43 cycles -> floor(43/4) = 10
    mede(43, tl, lt);
    chk("floor_distancia", distancia, 10);
    chk("floor_suficiente", suficiente, 1);

    // 3 cycles -> 0 cm, sufficient
    mede(3, tl, lt);
    chk("zero_distancia", distancia, 0);
    chk("zero_suficiente", suficiente, 1);
    chk("zero_pronto", pronto, 1);

    // New medir drops pronto on the next clock; then abort mid mede_echo
    medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("re_pronto", pronto, 0);
    chk("re_trigger", trigger, 1);
    n = 0;
    while (trigger && n < 50) begin
      n++;
      tick();
    end
    echo = 1'b1;
    repeat (20) tick();
    chk("abort_pre_estado", db_estado, 3);
    zera = 1'b1; medir = 1'b1;
    tick();
    zera = 1'b0; medir = 1'b0;
    chk("abort_estado", db_estado, 0);
    chk("abort_trigger", trigger, 0);
    chk("abort_pronto", pronto, 0);
    chk("abort_falha", falha, 0);
    chk("abort_distancia", distancia, 0);
    echo = 1'b0;
    repeat (8) tick();
    chk("abort_no_trigger", trigger, 0);
    chk("abort_idle", db_estado, 0);

    // No echo: 200 clocks in espera_echo (cont 0..199), one in falha_st,
    // falha visible after the following clock -> 201 clocks
    inicia(tl);
    n = 0;
    while (!falha && n < 1000) begin
      tick();
      n++;
    end
    chk("noecho_cycles", n, 201);
    chk("noecho_falha", falha, 1);
    chk("noecho_pronto", pronto, 0);
    chk("noecho_trigger", trigger, 0);
    chk("noecho_estado", db_estado, 0);

    // Stuck echo, already high on entering espera: 2 sync clocks, 1 to enter
    // mede_echo, 200 in mede_echo, 1 in falha_st -> falha after 204 clocks
    inicia(tl);
    echo = 1'b1;
    n = 0;
    while (!falha && n < 400) begin
      tick();
      n++;
    end
    chk("stuck_cycles", n, 204);
    chk("stuck_falha", falha, 1);
    chk("stuck_distancia", distancia, 0);
    chk("stuck_pronto", pronto, 0);
    chk("stuck_suficiente", suficiente, 0);
    if (n < 250) repeat (250 - n) tick();
    echo = 1'b0;
    repeat (5) tick();
    chk("stuck_idle", db_estado, 0);
    chk("stuck_falha_hold", falha, 1);

    // Saturation: 600 cycles at 1 per cm saturate to 511; medir ignored
    medir_s = 1'b1;
    tick();
    medir_s = 1'b0;
    n = 0;
    while (trigger_s && n < 50) begin
      n++;
      tick();
    end
    echo_sp = 1'b1;
    repeat (300) tick();
    medir_s = 1'b1;
    tick();
    medir_s = 1'b0;
    tick();
    chk("sat_ignore_trigger", trigger_s, 0);
    chk("sat_ignore_estado", db_estado_s, 3);
    repeat (298) tick();
    echo_sp = 1'b0;
    n = 0;
    while (!pronto_s && !falha_s && n < 20) begin
      tick();
      n++;
    end
    chk("sat_latency", n, 4);
    chk("sat_distancia", distancia_s, 511);
    chk("sat_suficiente", suficiente_s, 0);
    chk("sat_falha", falha_s, 0);

    // Asynchronous reset during gera_trigger drops trigger without a clock
    medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("ar_trigger_on", trigger, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_trigger_off", trigger, 0);
    chk("ar_estado", db_estado, 0);
    chk("ar_falha", falha, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_stays_idle", trigger, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
